// File: rtl/alu_cmd_driver_if.sv
// Command, ALU and result signals for alu_cmd_driver.
// The slave modport is the driver's side; the master modport is the command/ALU side.
interface alu_cmd_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [1:0]  cmd_sel;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [1:0]  Sel;
    logic [15:0] Z;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_z;
    logic [1:0]  res_sel;
    logic        busy;
    logic [7:0]  done_count;
    logic        mismatch;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, Z, res_ready,
        output cmd_ready, A, B, Sel, res_valid, res_z, res_sel, busy, done_count, mismatch
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, Z, res_ready,
        input  cmd_ready, A, B, Sel, res_valid, res_z, res_sel, busy, done_count, mismatch
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Single-outstanding ALU command driver: accept, wait ALU_LATENCY cycles, capture Z, hand off.
// Define ALU_DRV_CHECK_EN to build the result checker that drives mismatch.
module alu_cmd_driver #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input logic              clk,
    input logic              rst,
    alu_cmd_driver_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LATENCY);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [1:0]  r_sel;
    logic [15:0] r_res_z;
    logic [1:0]  r_res_sel;
    logic        r_res_valid;
    logic        r_busy;
    logic        r_cmd_ready;
    logic [7:0]  r_done_count;

    logic w_accept;
    logic w_capture;

    assign w_accept  = bus.cmd_valid && r_cmd_ready;
    assign w_capture = (r_state == WAIT) && (r_cnt == 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sel        <= '0;
            r_res_z      <= '0;
            r_res_sel    <= '0;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_done_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a         <= bus.cmd_a;
                        r_b         <= bus.cmd_b;
                        r_sel       <= bus.cmd_sel;
                        r_cnt       <= LAT_LOAD;
                        r_state     <= WAIT;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (w_capture) begin
                        r_res_z     <= bus.Z;
                        r_res_sel   <= r_sel;
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // cmd_ready rises only after leaving DONE, leaving one bubble per command
                    if (bus.res_ready) begin
                        r_res_valid  <= 1'b0;
                        r_done_count <= r_done_count + 8'd1;
                        r_state      <= IDLE;
                        r_cmd_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.A          = r_a;
    assign bus.B          = r_b;
    assign bus.Sel        = r_sel;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_z      = r_res_z;
    assign bus.res_sel    = r_res_sel;
    assign bus.busy       = r_busy;
    assign bus.done_count = r_done_count;

`ifdef ALU_DRV_CHECK_EN
    logic [15:0] w_expect;
    logic        r_mismatch;

    always_comb begin
        w_expect = '0;
        case (r_sel)
            2'b00:   w_expect = {8'h00, r_a} + {8'h00, r_b};
            2'b01:   w_expect = {8'h00, r_a} - {8'h00, r_b};
            2'b10:   w_expect = {8'h00, r_a} * {8'h00, r_b};
            default: w_expect = (r_b == 8'h00) ? 16'hFFFF : {8'h00, r_a / r_b};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else if (w_capture && (w_expect != bus.Z)) begin
            r_mismatch <= 1'b1;
        end
    end

    assign bus.mismatch = r_mismatch;
`else
    assign bus.mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver at ALU_LATENCY=1 and 4, with a combinational ALU model.
// Checker cases run when ALU_DRV_CHECK_EN is defined.
module tb_alu_cmd_driver;
    logic clk;
    logic rst;
    logic rst4;
    logic force_bad;
    int   n_checks;
    int   n_fail;
    logic [7:0] exp_done;

    alu_cmd_driver_if if0 ();
    alu_cmd_driver_if if4 ();

    alu_cmd_driver #(.ALU_LATENCY(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    alu_cmd_driver #(.ALU_LATENCY(4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (if4)
    );

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] sel);
        case (sel)
            2'b00:   return {8'h00, a} + {8'h00, b};
            2'b01:   return {8'h00, a} - {8'h00, b};
            2'b10:   return {8'h00, a} * {8'h00, b};
            default: return (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
        endcase
    endfunction

    assign if0.Z = force_bad ? 16'h0009 : alu_model(if0.A, if0.B, if0.Sel);
    assign if4.Z = alu_model(if4.A, if4.B, if4.Sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full command on the latency-1 instance with res_ready high.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                           input logic [15:0] exp_z, input logic exp_mm);
        if0.cmd_valid = 1'b1;
        if0.cmd_a     = a;
        if0.cmd_b     = b;
        if0.cmd_sel   = sel;
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
        check("acc_busy", 16'(if0.busy), 16'd1);
        check("acc_ready", 16'(if0.cmd_ready), 16'd0);
        check("acc_rvalid", 16'(if0.res_valid), 16'd0);
        check("acc_A", 16'(if0.A), 16'(a));
        check("acc_B", 16'(if0.B), 16'(b));
        check("acc_Sel", 16'(if0.Sel), 16'(sel));
        @(posedge clk); #1;
        check("cap_rvalid", 16'(if0.res_valid), 16'd1);
        check("cap_res_z", if0.res_z, exp_z);
        check("cap_res_sel", 16'(if0.res_sel), 16'(sel));
        check("cap_mismatch", 16'(if0.mismatch), 16'(exp_mm));
        @(posedge clk); #1;
        exp_done = exp_done + 8'd1;
        check("hs_rvalid", 16'(if0.res_valid), 16'd0);
        check("hs_ready", 16'(if0.cmd_ready), 16'd1);
        check("hs_busy", 16'(if0.busy), 16'd0);
        check("hs_done_count", 16'(if0.done_count), 16'(exp_done));
        check("hs_res_z_hold", if0.res_z, exp_z);
    endtask

    task automatic pulse_rst0();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_done = 8'd0;
        check("rst_done_count", 16'(if0.done_count), 16'd0);
        check("rst_mismatch", 16'(if0.mismatch), 16'd0);
        check("rst_ready", 16'(if0.cmd_ready), 16'd1);
    endtask

    initial begin
        int  cyc;
        int  last;
        int  acc_n;
        int  gap_bad;
        logic acc;
        logic seen_rv;

        n_checks  = 0;
        n_fail    = 0;
        exp_done  = 8'd0;
        force_bad = 1'b0;
        rst  = 1'b1;
        rst4 = 1'b1;
        if0.cmd_valid = 1'b0; if0.cmd_a = '0; if0.cmd_b = '0; if0.cmd_sel = '0; if0.res_ready = 1'b1;
        if4.cmd_valid = 1'b0; if4.cmd_a = '0; if4.cmd_b = '0; if4.cmd_sel = '0; if4.res_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_A", 16'(if0.A), 16'd0);
        check("rst_res_z", if0.res_z, 16'd0);
        check("rst_res_valid", 16'(if0.res_valid), 16'd0);
        check("rst_busy", 16'(if0.busy), 16'd0);
        check("rst_dc", 16'(if0.done_count), 16'd0);
        check("rst_mm", 16'(if0.mismatch), 16'd0);
        rst  = 1'b0;
        rst4 = 1'b0;
        check("rel_ready", 16'(if0.cmd_ready), 16'd1);

        // Arithmetic at latency 1
        run_cmd(8'd5, 8'd3, 2'b00, 16'd8, 1'b0);
        run_cmd(8'd6, 8'd1, 2'b01, 16'd5, 1'b0);
        run_cmd(8'd2, 8'd3, 2'b10, 16'd6, 1'b0);
        run_cmd(8'd6, 8'd2, 2'b11, 16'd3, 1'b0);

        // Backpressure, with a competing command offered during DONE
        if0.res_ready = 1'b0;
        if0.cmd_valid = 1'b1; if0.cmd_a = 8'd9; if0.cmd_b = 8'd4; if0.cmd_sel = 2'b10;
        @(posedge clk); #1;
        if0.cmd_a = 8'd77; if0.cmd_b = 8'd11; if0.cmd_sel = 2'b01;
        @(posedge clk); #1;
        check("bp_cap_rv", 16'(if0.res_valid), 16'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rv", 16'(if0.res_valid), 16'd1);
            check("bp_res_z", if0.res_z, 16'd36);
            check("bp_res_sel", 16'(if0.res_sel), 16'd2);
            check("bp_ready", 16'(if0.cmd_ready), 16'd0);
            check("bp_AB", {if0.A, if0.B}, {8'd9, 8'd4});
            check("bp_Sel", 16'(if0.Sel), 16'd2);
        end
        if0.cmd_valid = 1'b0;
        if0.res_ready = 1'b1;
        @(posedge clk); #1;
        exp_done = exp_done + 8'd1;
        check("bp_hs_rv", 16'(if0.res_valid), 16'd0);
        check("bp_hs_dc", 16'(if0.done_count), 16'(exp_done));
        check("bp_hs_A", 16'(if0.A), 16'd9);
        @(posedge clk); #1;
        check("bp_dc_once", 16'(if0.done_count), 16'(exp_done));

`ifdef ALU_DRV_CHECK_EN
        force_bad = 1'b1;
        run_cmd(8'd5, 8'd3, 2'b00, 16'h0009, 1'b1);
        force_bad = 1'b0;
        run_cmd(8'd2, 8'd3, 2'b10, 16'd6, 1'b1);
        pulse_rst0();
        run_cmd(8'd1, 8'd2, 2'b01, 16'hFFFF, 1'b0);
        run_cmd(8'd7, 8'd0, 2'b11, 16'hFFFF, 1'b0);
`else
        force_bad = 1'b1;
        run_cmd(8'd5, 8'd3, 2'b00, 16'h0009, 1'b0);
        force_bad = 1'b0;
        run_cmd(8'd1, 8'd2, 2'b01, 16'hFFFF, 1'b0);
`endif

        // Latency 4: command held through WAIT must be ignored
        if4.cmd_valid = 1'b1; if4.cmd_a = 8'd5; if4.cmd_b = 8'd3; if4.cmd_sel = 2'b00;
        @(posedge clk); #1;
        if4.cmd_a = 8'hAA;
        check("l4_busy", 16'(if4.busy), 16'd1);
        @(posedge clk); #1;
        if4.cmd_valid = 1'b0;
        check("l4_A_hold", 16'(if4.A), 16'd5);
        repeat (2) @(posedge clk);
        #1;
        check("l4_rv_early", 16'(if4.res_valid), 16'd0);
        @(posedge clk); #1;
        check("l4_rv", 16'(if4.res_valid), 16'd1);
        check("l4_res_z", if4.res_z, 16'd8);
        @(posedge clk); #1;
        check("l4_dc", 16'(if4.done_count), 16'd1);

        // Reset in WAIT discards the command
        if4.cmd_valid = 1'b1; if4.cmd_a = 8'd9; if4.cmd_b = 8'd9; if4.cmd_sel = 2'b10;
        @(posedge clk); #1;
        if4.cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        check("mr_AB", {if4.A, if4.B}, 16'd0);
        check("mr_Sel", 16'(if4.Sel), 16'd0);
        check("mr_res", if4.res_z, 16'd0);
        check("mr_flags", {13'd0, if4.res_valid, if4.busy, if4.mismatch}, 16'd0);
        check("mr_dc", 16'(if4.done_count), 16'd0);
        check("mr_ready", 16'(if4.cmd_ready), 16'd1);
        seen_rv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (if4.res_valid) seen_rv = 1'b1;
        end
        check("mr_no_result", 16'(seen_rv), 16'd0);

        // Wrap: 256 back-to-back commands from a freshly reset count
        pulse_rst0();
        if0.cmd_valid = 1'b1; if0.cmd_a = 8'd0; if0.cmd_b = 8'd1; if0.cmd_sel = 2'b00;
        cyc = 0; last = 0; acc_n = 0; gap_bad = 0;
        while (acc_n < 256 && cyc < 2000) begin
            acc = if0.cmd_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (acc_n > 0 && (cyc - last) != 3) gap_bad++;
                last = cyc;
                acc_n++;
                if0.cmd_a = 8'(acc_n);
                if (acc_n == 256) check("wrap_dc255", 16'(if0.done_count), 16'd255);
            end
        end
        if0.cmd_valid = 1'b0;
        check("wrap_accepts", 16'(acc_n), 16'd256);
        check("wrap_gap", 16'(gap_bad), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check("wrap_dc0", 16'(if0.done_count), 16'd0);
        check("wrap_idle", 16'(if0.cmd_ready), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
